wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between four write-back requesters: 0 = ALU, 1 = load unit, 2 = PC+4 link, 3 = CSR read.
- Arbitrates with a round-robin policy and a valid/ready handshake.
- Registers the winner's select code, destination and data into a one-stage write-back register that drives the register file.
- Sits between the MEM/WB boundary and the register file, and produces the write-back select code.

Parameters:
- DW, 32, data width of each requester and of the register-file write data.
- AW, 5, register-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- stall  input  1  freezes arbitration; no grants while high.
- req_valid  input  4  per-requester write request; bit i = requester i.
- req_ready  output  4  per-requester accept; at most one bit high per cycle.
- req_rd0..req_rd3  input  AW each  destination register of requester i.
- req_data0..req_data3  input  DW each  write data of requester i.
- wb_sel  output  2  registered index of the last granted requester; 00=ALU, 01=load, 10=PC+4, 11=CSR.
- rf_we  output  1  registered register-file write enable.
- rf_waddr  output  AW  registered write address.
- rf_wdata  output  DW  registered write data.
- rr_ptr  output  2  current round-robin priority pointer (debug/verification).

Behaviour:
- Reset: one clock synchronous, active-low.
  - Effects while rst_n=0 at a rising edge: rf_we=0, rf_waddr=0, rf_wdata=0, wb_sel=00, rr_ptr=00.
  - req_ready is combinational and forced to 0 while rst_n=0.
- Grant (combinational):
  - When stall=0 and rst_n=1: search req_valid starting at index rr_ptr, ascending and wrapping 3->0. The first set bit i wins and req_ready[i]=1; all other ready bits are 0.
  - When no request is valid: req_ready=0.
  - When stall=1: req_ready=0.
- Handshake:
  - A transfer happens on a rising edge where req_valid[i]=1 and req_ready[i]=1.
  - A requester holding valid=1 without ready must keep rd and data stable and must not drop valid.
  - Ready does not depend on any registered back-pressure; only stall and rr_ptr gate it.
- Latency:
  - A transfer at edge N makes wb_sel=i, rf_waddr=req_rdi and rf_wdata=req_datai visible after edge N.
  - rf_we is 1 for exactly the following cycle. The register file writes at edge N+1.
- x0 rule:
  - A transfer with rd=0 is accepted (ready pulses, pointer advances) and wb_sel, rf_waddr and rf_wdata update.
  - rf_we stays 0.
- Idle cycle (no transfer, including stall=1): rf_we=0. wb_sel, rf_waddr and rf_wdata hold their previous values.
- Round-robin pointer:
  - On a transfer from requester i, rr_ptr <= (i+1) mod 4, wrapping 3->0.
  - With no transfer, rr_ptr holds.
  - Fairness: a continuously valid requester is granted within 4 non-stalled cycles.
- Back-to-back: one transfer per non-stalled cycle maximum; consecutive transfers give rf_we=1 on consecutive cycles.
- Simultaneous events:
  - stall=1 with all four valid: no grant, pointer holds.
  - A request arriving in the same cycle stall deasserts is eligible in that cycle.
- Reset mid-operation:
  - A pending request that was not yet accepted is lost to the arbiter; the requester re-presents it after reset.
  - A write-back register holding rf_we=1 is cleared by reset and the write is not performed.
- Width: data passes unmodified, with no extension or truncation; all indices are 2 bits modulo 4.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles, then req_valid=0001, rd0=5, data0=0xDEADBEEF.
   - req_ready=0001 the same cycle.
   - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_sel=00, rr_ptr=01.
2. Round-robin rotation: req_valid=1111 held for 8 cycles from rr_ptr=00.
   - Grant order is 0,1,2,3,0,1,2,3.
   - rf_we=1 on every cycle from the second onward.
   - wb_sel follows the grant order one cycle late.
3. Stall: req_valid=0110 with stall=1 for 3 cycles.
   - req_ready=0000, rf_we=0, rr_ptr unchanged.
   - stall drops with rr_ptr=00: requester 1 granted, then requester 2.
4. x0 suppression: req_valid=1000, rd3=0, data3=0x1234.
   - ready[3]=1, rr_ptr=00 next cycle.
   - wb_sel=11, rf_wdata=0x1234, rf_we=0.
5. Pointer wrap and skip: rr_ptr=11, req_valid=0101.
   - Requester 0 granted (wrap past empty 3), rr_ptr=01.
   - Next grant goes to requester 2, rr_ptr=11.
6. Reset mid-operation: transfer accepted at edge N; rst_n=0 sampled at edge N+1.
   - rf_we is 0 after edge N+1 and the write is not performed.
   - All outputs at reset values; req_ready=0000 while rst_n=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: four requesters (ALU, load, PC+4 link, CSR) share
// the single register-file write port under a round-robin valid/ready
// handshake. The winner's select code, destination and data are captured in
// a one-stage write-back register that drives the register file.
module wb_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic [3:0]    req_valid,
  output logic [3:0]    req_ready,
  input  logic [AW-1:0] req_rd0,
  input  logic [AW-1:0] req_rd1,
  input  logic [AW-1:0] req_rd2,
  input  logic [AW-1:0] req_rd3,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [DW-1:0] req_data2,
  input  logic [DW-1:0] req_data3,
  output logic [1:0]    wb_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [1:0]    rr_ptr
);

  logic          grant_any;
  logic [1:0]    grant_idx;
  logic [1:0]    scan_idx;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_data;
  logic          we_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping 3->0.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = rr_ptr + 2'(k);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    req_ready = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  // Select the winning requester's destination and data.
  always_comb begin
    win_rd   = req_rd0;
    win_data = req_data0;
    case (grant_idx)
      2'd1: begin win_rd = req_rd1; win_data = req_data1; end
      2'd2: begin win_rd = req_rd2; win_data = req_data2; end
      2'd3: begin win_rd = req_rd3; win_data = req_data3; end
      default: ;
    endcase
  end

  // Write-back register and priority pointer; idle cycles hold all but the enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      we_q     <= 1'b0;
      wb_sel   <= 2'b00;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= 2'b00;
    end else if (grant_any) begin
      // Writes to x0 are accepted and tracked but never enabled.
      we_q     <= (win_rd != '0);
      wb_sel   <= grant_idx;
      rf_waddr <= win_rd;
      rf_wdata <= win_data;
      rr_ptr   <= grant_idx + 2'd1;
    end else begin
      we_q     <= 1'b0;
    end
  end

  // A pending write is squashed as soon as reset is asserted, so the register
  // file never commits it at the reset edge.
  assign rf_we = we_q & rst_n;

endmodule
